// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FWFT FIFO with occupancy, almost-full and sticky error flags
module sync_fifo #(
  parameter int DLEN      = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wen,
  input  logic [DLEN-1:0]          i_wdata,
  output logic                     o_wfull,
  output logic                     o_afull,
  input  logic                     i_ren,
  output logic [DLEN-1:0]          o_rdata,
  output logic                     o_rempty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_ovf,
  output logic                     o_udf
);

  localparam int ADDR = $clog2(DEPTH);
  localparam logic [ADDR:0] PTR_ONE   = {{ADDR{1'b0}}, 1'b1};
  localparam logic [ADDR:0] AFULL_CNT = AFULL_LVL[ADDR:0];

  logic [DLEN-1:0] mem [DEPTH];
  logic [ADDR:0]   wptr;
  logic [ADDR:0]   rptr;
  logic            wr_ok;
  logic            rd_ok;

  // Flags come straight from the registered pointers; the MSB is the wrap bit.
  assign o_rempty = (wptr == rptr);
  assign o_wfull  = (wptr[ADDR-1:0] == rptr[ADDR-1:0]) && (wptr[ADDR] != rptr[ADDR]);
  assign o_count  = wptr - rptr;
  assign o_afull  = (o_count >= AFULL_CNT);
  assign o_rdata  = mem[rptr[ADDR-1:0]];

  assign wr_ok = i_wen & ~o_wfull;
  assign rd_ok = i_ren & ~o_rempty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      o_ovf <= 1'b0;
      o_udf <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + PTR_ONE;
      if (rd_ok) rptr <= rptr + PTR_ONE;
      if (i_wen & o_wfull)  o_ovf <= 1'b1;
      if (i_ren & o_rempty) o_udf <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[ADDR-1:0]] <= i_wdata;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Synchronous single-clock FIFO storage core. It sits directly downstream of the AXI4-Stream slave write stage: it absorbs that stage's `o_wen`/`o_wdata` strobe and returns the full indication that stage consumes as `i_wfull`. The read port is first-word-fall-through (FWFT) for the AXI4-Stream master read stage. Occupancy count, almost-full and sticky error flags are provided for status and debug.

## Interface
- `DLEN`, 8: data width in bits.
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `AFULL_LVL`, 12: `o_afull` asserts when occupancy ≥ this value; range 1..DEPTH.

One clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_wen`  in  1  write strobe, from the write stage's `o_wen`.
- `i_wdata`  in  DLEN  write data.
- `o_wfull`  out  1  FIFO full; feeds the write stage's `i_wfull`.
- `o_afull`  out  1  occupancy ≥ AFULL_LVL.
- `i_ren`  in  1  pop strobe for the head entry.
- `o_rdata`  out  DLEN  head entry (FWFT); valid only when `o_rempty`=0.
- `o_rempty`  out  1  FIFO empty.
- `o_count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `o_ovf`  out  1  sticky: a write was attempted while full.
- `o_udf`  out  1  sticky: a read was attempted while empty.

## Operation
- Storage: register array of DEPTH×DLEN. The array is not reset.
- Pointers: `wptr` and `rptr`, each $clog2(DEPTH)+1 bits. The MSB is a wrap bit. The low bits index the array.
- Full and empty, derived from the registered pointers:
  - Empty: `wptr == rptr`.
  - Full: low bits equal and MSBs differ.
  - `o_count` = `wptr - rptr`, modulo 2^(ADDR+1).
- Write accepted iff `i_wen & ~o_wfull`:
  - `mem[wptr]` ← `i_wdata`.
  - `wptr` increments. Natural wrap: DEPTH-1 → 0 on the low bits, MSB toggles.
- Read accepted iff `i_ren & ~o_rempty`: `rptr` increments.
- `o_rdata` = `mem[rptr[ADDR-1:0]]`, combinational from the registered pointer. Its value is don't-care while empty.
- Rejected accesses:
  - `i_wen` while full: no state change; `o_ovf` sets.
  - `i_ren` while empty: no state change; `o_udf` sets.
  - `o_ovf` and `o_udf` clear only on reset.
- Simultaneous write and read:
  - Not full and not empty: both accepted; count unchanged.
  - Full: read accepted, write rejected and `o_ovf` sets. Full is evaluated before the edge; there is no write-through-when-full.
  - Empty: write accepted, read rejected and `o_udf` sets. There is no bypass; data appears on the next cycle.
- Reset (async assert, at any time including mid-transfer):
  - `wptr` = `rptr` = 0.
  - `o_rempty`=1, `o_wfull`=0, `o_afull`=0, `o_count`=0, `o_ovf`=0, `o_udf`=0.
  - Contents are discarded logically.
- Reset deassertion is assumed synchronized externally. The first accepted access is on the first rising edge with `rst`=0.

## Timing
- All flags and `o_count` are combinational from registered pointers. They reflect every access accepted at edge N during cycle N+1.
- Write-to-read latency is 1 cycle. A word written at edge N:
  - drops `o_rempty` during cycle N+1;
  - appears on `o_rdata` during cycle N+1 if the FIFO was empty.
- A pop at edge N presents the next entry on `o_rdata` in cycle N+1.
- `o_wfull` asserts in the cycle after the DEPTH-th outstanding write is accepted. The write stage's skid buffer absorbs the in-flight beat, so there is no combinational full-to-ready path from this block.
- Sustained throughput is one write and one read per cycle.

## Test plan
- **Reset:** assert `rst` mid-stream with count=5 → same cycle: `o_rempty`=1, `o_count`=0, flags 0. After release, a write of 0xA5 → `o_rdata`=0xA5 next cycle.
- **Fill and drain:** DEPTH=16; write 0x00..0x0F with no reads:
  - `o_afull` rises after the 12th write;
  - `o_wfull` rises after the 16th write;
  - a 17th write sets `o_ovf` and leaves data intact;
  - draining returns 0x00..0x0F in order, then `o_rempty`=1.
- **Wrap-around:** 40 writes interleaved with reads, keeping occupancy between 3 and 7 → data order preserved across pointer wrap; `o_count` tracks the model every cycle.
- **Simultaneous access at full:** full FIFO with `i_wen`=`i_ren`=1 → head popped, write dropped, `o_count`=15, `o_ovf`=1.
- **Simultaneous access at empty:** empty FIFO with `i_wen`=`i_ren`=1 and data 0x3C → `o_udf`=1, `o_count`=1, `o_rdata`=0x3C next cycle.
- **Streaming:** continuous write and read every cycle for 100 cycles after priming 1 entry → `o_count` stays 1, no flag asserts, and output equals input delayed by one entry.
